// File: rtl/bcd_display_scanner_if.sv
// Display-scanner bus: the packed BCD value and blanking request coming in
// from the display-data multiplexer, and the 7-segment pin drives going out.
interface bcd_display_scanner_if;
    logic [15:0] data_bcd;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    modport master (
        output data_bcd, blank_lz,
        input  seg, an, frame_done
    );

    modport slave (
        input  data_bcd, blank_lz,
        output seg, an, frame_done
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a 4-digit packed BCD value onto a common-anode 7-segment
// display. The value is snapshotted once per frame (no tearing), leading
// zeros can be blanked, and every digit slot opens with an all-off window
// to suppress ghosting. an/seg are registered from next-state values so
// they line up with the prescaler/digit state without extra latency.
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 64
) (
    input logic                   clk,
    input logic                   rst,
    bcd_display_scanner_if.slave  bus
);

    localparam int              PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   BLANK_P  = PW'(BLANK_CYC);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   snap_q, snap_d;
    logic          lz_q, lz_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          fd_q, fd_d;

    logic [3:0]    nib;
    logic          hz3, hz2, hz1;
    logic          lz_blank;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next scan state: prescaler wrap steps the digit; wrapping out of digit 3 takes a new snapshot.
    always_comb begin
        pre_d  = pre_q + PW'(1);
        dig_d  = dig_q;
        snap_d = snap_q;
        lz_d   = lz_q;
        fd_d   = 1'b0;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            dig_d = dig_q + 2'd1;
            if (dig_q == 2'd3) begin
                snap_d = bus.data_bcd;
                lz_d   = bus.blank_lz;
                fd_d   = 1'b1;
            end
        end
    end

    // Next pin drive: pick the nibble for the upcoming digit and decide whether it is suppressed.
    always_comb begin
        hz3 = (snap_d[15:12] == 4'd0);
        hz2 = hz3 && (snap_d[11:8] == 4'd0);
        hz1 = hz2 && (snap_d[7:4] == 4'd0);
        case (dig_d)
            2'd0:    nib = snap_d[3:0];
            2'd1:    nib = snap_d[7:4];
            2'd2:    nib = snap_d[11:8];
            default: nib = snap_d[15:12];
        endcase
        case (dig_d)
            2'd1:    lz_blank = lz_d && hz1;
            2'd2:    lz_blank = lz_d && hz2;
            2'd3:    lz_blank = lz_d && hz3;
            default: lz_blank = 1'b0;
        endcase
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        if (!(pre_d < BLANK_P) && !lz_blank) begin
            an_d  = ~(4'b0001 << dig_d);
            seg_d = seg_decode(nib);
        end
    end

    // Scan state and pin registers; reset forces every anode and segment off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            dig_q  <= 2'd0;
            snap_q <= 16'h0000;
            lz_q   <= 1'b0;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
            fd_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            dig_q  <= dig_d;
            snap_q <= snap_d;
            lz_q   <= lz_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            fd_q   <= fd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner with REFRESH_DIV=4, BLANK_CYC=1. A reference
// model derives the expected pins from the number of clock edges since reset
// and the value latched at each frame start.
module tb_bcd_display_scanner;

    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 4 * RD;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bcd_display_scanner_if ifc ();

    bcd_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: edge count since reset plus the frame snapshot.
    int unsigned n      = 0;
    logic [15:0] m_snap = 16'h0000;
    logic        m_lz   = 1'b0;
    logic        m_fd   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n      <= 0;
            m_snap <= 16'h0000;
            m_lz   <= 1'b0;
            m_fd   <= 1'b0;
        end else begin
            n <= n + 1;
            if (((n + 1) % FRAME) == 0) begin
                m_snap <= ifc.data_bcd;
                m_lz   <= ifc.blank_lz;
                m_fd   <= 1'b1;
            end else begin
                m_fd   <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {an, seg} for the current model state.
    function automatic logic [10:0] model_out();
        int pos;
        int dig;
        logic [15:0] upper;
        pos   = int'(n % RD);
        dig   = int'((n / RD) % 4);
        upper = m_snap >> (4 * dig);
        if (pos < BC)
            return {4'b1111, 7'b1111111};
        if (m_lz && dig != 0 && upper == 16'h0000)
            return {4'b1111, 7'b1111111};
        return {~(4'b0001 << dig), seg_of(int'(upper[3:0]))};
    endfunction

    // Advance at least one cycle, then up to two frames until n%FRAME == r.
    task automatic sync_to(input int r);
        int k;
        @(negedge clk);
        k = 0;
        while ((n % FRAME) != r && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if ((n % FRAME) != r) begin
            n_bad++;
            $display("FAIL sync_to: phase %0d, required %0d", n % FRAME, r);
        end
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst = 1'b0;
        ifc.data_bcd = 16'h1234;
        ifc.blank_lz = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (ifc.an !== 4'b1111 || ifc.seg !== 7'b1111111 || ifc.frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: an=%b seg=%b fd=%b, required 1111 1111111 0",
                         ifc.an, ifc.seg, ifc.frame_done);
            end
        end
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ifc.an !== 4'b1110 || ifc.seg !== 7'b1000000) begin
                n_bad++;
                $display("FAIL reset_first_slot c%0d: an=%b seg=%b, required 1110 1000000",
                         i, ifc.an, ifc.seg);
            end
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            e = model_out();
            n_cmp++;
            if ({ifc.an, ifc.seg} !== e || ifc.frame_done !== m_fd) begin
                n_bad++;
                $display("FAIL reset_first_frame n=%0d: an=%b seg=%b fd=%b, required an=%b seg=%b fd=%b",
                         n, ifc.an, ifc.seg, ifc.frame_done, e[10:7], e[6:0], m_fd);
            end
        end
    endtask

    task automatic test_steady();
        logic [10:0] e;
        logic [10:0] k;
        int last;
        last = -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            e = model_out();
            n_cmp++;
            if ({ifc.an, ifc.seg} !== e || ifc.frame_done !== m_fd) begin
                n_bad++;
                $display("FAIL steady n=%0d: an=%b seg=%b fd=%b, required an=%b seg=%b fd=%b",
                         n, ifc.an, ifc.seg, ifc.frame_done, e[10:7], e[6:0], m_fd);
            end
            k = 11'h000;
            case (n % FRAME)
                1:  k = {4'b1110, 7'b0011001};
                5:  k = {4'b1101, 7'b0110000};
                9:  k = {4'b1011, 7'b0100100};
                13: k = {4'b0111, 7'b1111001};
                0:  k = {4'b1111, 7'b1111111};
                default: k = 11'h000;
            endcase
            if (k != 11'h000) begin
                n_cmp++;
                if ({ifc.an, ifc.seg} !== k) begin
                    n_bad++;
                    $display("FAIL steady_const phase=%0d: an=%b seg=%b, required an=%b seg=%b",
                             n % FRAME, ifc.an, ifc.seg, k[10:7], k[6:0]);
                end
            end
            if (ifc.frame_done === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (i - last != FRAME) begin
                        n_bad++;
                        $display("FAIL frame_period: %0d cycles, required %0d", i - last, FRAME);
                    end
                end
                last = i;
            end
        end
    endtask

    task automatic test_tearing();
        logic [10:0] e;
        logic [10:0] k;
        sync_to(5);
        ifc.data_bcd = 16'h9876;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            e = model_out();
            n_cmp++;
            if ({ifc.an, ifc.seg} !== e || ifc.frame_done !== m_fd) begin
                n_bad++;
                $display("FAIL tearing n=%0d: an=%b seg=%b fd=%b, required an=%b seg=%b fd=%b",
                         n, ifc.an, ifc.seg, ifc.frame_done, e[10:7], e[6:0], m_fd);
            end
            case (i)
                3:  k = {4'b1011, 7'b0100100};
                7:  k = {4'b0111, 7'b1111001};
                11: k = {4'b1110, 7'b0000010};
                15: k = {4'b1101, 7'b1111000};
                19: k = {4'b1011, 7'b0000000};
                23: k = {4'b0111, 7'b0010000};
                default: k = 11'h000;
            endcase
            if (k != 11'h000) begin
                n_cmp++;
                if ({ifc.an, ifc.seg} !== k) begin
                    n_bad++;
                    $display("FAIL tearing_const i=%0d: an=%b seg=%b, required an=%b seg=%b",
                             i, ifc.an, ifc.seg, k[10:7], k[6:0]);
                end
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [10:0] e;
        logic [10:0] k;
        ifc.data_bcd = 16'h0050;
        ifc.blank_lz = 1'b1;
        sync_to(1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            e = model_out();
            n_cmp++;
            if ({ifc.an, ifc.seg} !== e) begin
                n_bad++;
                $display("FAIL lz_0050 n=%0d: an=%b seg=%b, required an=%b seg=%b",
                         n, ifc.an, ifc.seg, e[10:7], e[6:0]);
            end
            if ((n % FRAME) >= 8) k = {4'b1111, 7'b1111111};
            else if ((n % FRAME) == 5) k = {4'b1101, 7'b0010010};
            else if ((n % FRAME) == 1) k = {4'b1110, 7'b1000000};
            else k = 11'h000;
            if (k != 11'h000) begin
                n_cmp++;
                if ({ifc.an, ifc.seg} !== k) begin
                    n_bad++;
                    $display("FAIL lz_0050_const phase=%0d: an=%b seg=%b, required an=%b seg=%b",
                             n % FRAME, ifc.an, ifc.seg, k[10:7], k[6:0]);
                end
            end
        end
        ifc.data_bcd = 16'h0000;
        sync_to(1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if ((n % FRAME) >= 1 && (n % FRAME) <= 3) k = {4'b1110, 7'b1000000};
            else k = {4'b1111, 7'b1111111};
            n_cmp++;
            if ({ifc.an, ifc.seg} !== k) begin
                n_bad++;
                $display("FAIL lz_0000 phase=%0d: an=%b seg=%b, required an=%b seg=%b",
                         n % FRAME, ifc.an, ifc.seg, k[10:7], k[6:0]);
            end
        end
    endtask

    task automatic test_invalid_bcd();
        logic [10:0] k;
        ifc.data_bcd = 16'hA0F3;
        ifc.blank_lz = 1'b1;
        sync_to(1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            case (n % FRAME)
                13: k = {4'b0111, 7'b0111111};
                9:  k = {4'b1011, 7'b1000000};
                5:  k = {4'b1101, 7'b0111111};
                1:  k = {4'b1110, 7'b0110000};
                default: k = 11'h000;
            endcase
            if (k != 11'h000) begin
                n_cmp++;
                if ({ifc.an, ifc.seg} !== k) begin
                    n_bad++;
                    $display("FAIL invalid_bcd phase=%0d: an=%b seg=%b, required an=%b seg=%b",
                             n % FRAME, ifc.an, ifc.seg, k[10:7], k[6:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] e;
        logic [15:0] v;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            e = model_out();
            n_cmp++;
            if ({ifc.an, ifc.seg} !== e || ifc.frame_done !== m_fd) begin
                n_bad++;
                $display("FAIL random n=%0d data=%h: an=%b seg=%b fd=%b, required an=%b seg=%b fd=%b",
                         n, m_snap, ifc.an, ifc.seg, ifc.frame_done, e[10:7], e[6:0], m_fd);
            end
            if ($urandom_range(0, 5) == 0) begin
                v = 16'($urandom);
                for (int d = 0; d < 4; d++)
                    if ($urandom_range(0, 1) == 1) v[4*d +: 4] = 4'h0;
                ifc.data_bcd = v;
                ifc.blank_lz = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] e;
        ifc.data_bcd = 16'h5678;
        ifc.blank_lz = 1'b0;
        sync_to(1);
        sync_to(9);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (ifc.an !== 4'b1111 || ifc.seg !== 7'b1111111 || ifc.frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: an=%b seg=%b fd=%b, required 1111 1111111 0",
                     ifc.an, ifc.seg, ifc.frame_done);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ifc.an !== 4'b1110 || ifc.seg !== 7'b1000000) begin
            n_bad++;
            $display("FAIL async_restart: an=%b seg=%b, required 1110 1000000", ifc.an, ifc.seg);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            e = model_out();
            n_cmp++;
            if ({ifc.an, ifc.seg} !== e || ifc.frame_done !== m_fd) begin
                n_bad++;
                $display("FAIL async_after n=%0d: an=%b seg=%b fd=%b, required an=%b seg=%b fd=%b",
                         n, ifc.an, ifc.seg, ifc.frame_done, e[10:7], e[6:0], m_fd);
            end
        end
    endtask

    initial begin
        ifc.data_bcd = 16'h0000;
        ifc.blank_lz = 1'b0;
        test_reset();
        test_steady();
        test_tearing();
        test_lz_blank();
        test_invalid_bcd();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
